// File: rtl/resize_channel_scheduler.sv
// resize_channel_scheduler
// Runs the bilinear resize controller once per feature-map channel and
// relocates the controller's plane-relative addresses into absolute
// feature-memory addresses using per-channel plane strides.
//
// Optional feature macro: RESIZE_SCHED_ABORT_EN
//   adds input `abort` and output `aborted`; an abort in LAUNCH/RUN/DRAIN
//   jumps straight to FINISH, and `aborted` accompanies that `done` pulse.
//
// state  | meaning
// IDLE   | waiting for start; configuration captured on the accepting edge
// LAUNCH | rc_enable low one cycle so the controller restarts at its origin
// RUN    | rc_enable high, waiting for rc_done
// DRAIN  | rc_enable low one cycle; last address leaves the output register
// FINISH | one-cycle done pulse, then back to IDLE

module resize_channel_scheduler #(
    parameter int ADDR_W = 16,
    parameter int CH_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CH_W-1:0]   num_ch,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] des_base,
    input  logic [ADDR_W-1:0] src_stride,
    input  logic [ADDR_W-1:0] des_stride,
    output logic              rc_enable,
    input  logic              rc_done,
    input  logic [ADDR_W-1:0] rc_src_addr1,
    input  logic [ADDR_W-1:0] rc_src_addr2,
    input  logic [ADDR_W-1:0] rc_des_addr,
    input  logic              rc_stage_flag,
    output logic [ADDR_W-1:0] mem_src_addr1,
    output logic [ADDR_W-1:0] mem_src_addr2,
    output logic [ADDR_W-1:0] mem_des_addr,
    output logic              mem_stage_flag,
    output logic              mem_valid,
    output logic [CH_W-1:0]   ch_idx,
    output logic              busy,
`ifdef RESIZE_SCHED_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic              done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     num_ch_q, num_ch_d;
    logic [CH_W-1:0]     ch_idx_q, ch_idx_d;
    logic [ADDR_W-1:0]   src_stride_q, src_stride_d;
    logic [ADDR_W-1:0]   des_stride_q, des_stride_d;
    logic [ADDR_W-1:0]   cur_src_q, cur_src_d;
    logic [ADDR_W-1:0]   cur_des_q, cur_des_d;

    logic [ADDR_W-1:0]   mem_src_addr1_q, mem_src_addr1_d;
    logic [ADDR_W-1:0]   mem_src_addr2_q, mem_src_addr2_d;
    logic [ADDR_W-1:0]   mem_des_addr_q, mem_des_addr_d;
    logic                mem_stage_flag_q, mem_stage_flag_d;
    logic                mem_valid_q, mem_valid_d;

    logic                last_ch;
    logic                abort_hit;

`ifdef RESIZE_SCHED_ABORT_EN
    logic                aborted_q, aborted_d;

    // Abort only has meaning while a channel is in flight.
    assign abort_hit = abort & ((state_q == ST_LAUNCH) |
                                (state_q == ST_RUN)    |
                                (state_q == ST_DRAIN));
    assign aborted_d = abort_hit;
    assign aborted   = aborted_q;
`else
    assign abort_hit = 1'b0;
`endif

    // DRAIN is only reachable with a non-zero channel count, so num_ch_q-1 cannot underflow there.
    assign last_ch = (ch_idx_q == (num_ch_q - CH_W'(1)));

    // Next-state, channel counter and current plane bases.
    always_comb begin
        state_d      = state_q;
        num_ch_d     = num_ch_q;
        ch_idx_d     = ch_idx_q;
        src_stride_d = src_stride_q;
        des_stride_d = des_stride_q;
        cur_src_d    = cur_src_q;
        cur_des_d    = cur_des_q;

        if (abort_hit) begin
            state_d = ST_FINISH;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        num_ch_d     = num_ch;
                        src_stride_d = src_stride;
                        des_stride_d = des_stride;
                        cur_src_d    = src_base;
                        cur_des_d    = des_base;
                        ch_idx_d     = '0;
                        state_d      = (num_ch == '0) ? ST_FINISH : ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (rc_done) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_ch) begin
                        state_d = ST_FINISH;
                    end else begin
                        ch_idx_d  = ch_idx_q + CH_W'(1);
                        cur_src_d = cur_src_q + src_stride_q;
                        cur_des_d = cur_des_q + des_stride_q;
                        state_d   = ST_LAUNCH;
                    end
                end
                ST_FINISH: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Address relocation stage; sums wrap at ADDR_W bits by construction.
    always_comb begin
        mem_src_addr1_d  = cur_src_q + rc_src_addr1;
        mem_src_addr2_d  = cur_src_q + rc_src_addr2;
        mem_des_addr_d   = cur_des_q + rc_des_addr;
        mem_stage_flag_d = rc_stage_flag;
        mem_valid_d      = (state_q == ST_RUN) & ~rc_done & ~abort_hit;
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            num_ch_q     <= '0;
            ch_idx_q     <= '0;
            src_stride_q <= '0;
            des_stride_q <= '0;
            cur_src_q    <= '0;
            cur_des_q    <= '0;
        end else begin
            state_q      <= state_d;
            num_ch_q     <= num_ch_d;
            ch_idx_q     <= ch_idx_d;
            src_stride_q <= src_stride_d;
            des_stride_q <= des_stride_d;
            cur_src_q    <= cur_src_d;
            cur_des_q    <= cur_des_d;
        end
    end

    // Output address register, one cycle behind the rc_* inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_src_addr1_q  <= '0;
            mem_src_addr2_q  <= '0;
            mem_des_addr_q   <= '0;
            mem_stage_flag_q <= 1'b0;
            mem_valid_q      <= 1'b0;
        end else begin
            mem_src_addr1_q  <= mem_src_addr1_d;
            mem_src_addr2_q  <= mem_src_addr2_d;
            mem_des_addr_q   <= mem_des_addr_d;
            mem_stage_flag_q <= mem_stage_flag_d;
            mem_valid_q      <= mem_valid_d;
        end
    end

`ifdef RESIZE_SCHED_ABORT_EN
    // Abort flag lines up with the FINISH cycle it caused.
    always_ff @(posedge clk) begin
        if (reset) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end
`endif

    // Control outputs decode straight from the state register so reset drops them at the edge.
    assign rc_enable      = (state_q == ST_RUN);
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_FINISH);
    assign ch_idx         = ch_idx_q;
    assign mem_src_addr1  = mem_src_addr1_q;
    assign mem_src_addr2  = mem_src_addr2_q;
    assign mem_des_addr   = mem_des_addr_q;
    assign mem_stage_flag = mem_stage_flag_q;
    assign mem_valid      = mem_valid_q;

endmodule

// File: tb/tb_resize_channel_scheduler.sv
// Testbench for resize_channel_scheduler: directed table, reset/abort
// sequences and randomized layers checked against a schedule model.

module tb_resize_channel_scheduler;

    localparam int ADDR_W = 16;
    localparam int CH_W   = 10;

    localparam int P_IDLE   = 0;
    localparam int P_LAUNCH = 1;
    localparam int P_RUN    = 2;
    localparam int P_DRAIN  = 3;
    localparam int P_FINISH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [CH_W-1:0]   num_ch;
    logic [ADDR_W-1:0] src_base, des_base, src_stride, des_stride;
    logic              rc_enable;
    logic              rc_done;
    logic [ADDR_W-1:0] rc_src_addr1, rc_src_addr2, rc_des_addr;
    logic              rc_stage_flag;
    logic [ADDR_W-1:0] mem_src_addr1, mem_src_addr2, mem_des_addr;
    logic              mem_stage_flag;
    logic              mem_valid;
    logic [CH_W-1:0]   ch_idx;
    logic              busy;
    logic              done;
`ifdef RESIZE_SCHED_ABORT_EN
    logic              abort;
    logic              aborted;
`endif

    always #5 clk = ~clk;

    resize_channel_scheduler #(.ADDR_W(ADDR_W), .CH_W(CH_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_ch         (num_ch),
        .src_base       (src_base),
        .des_base       (des_base),
        .src_stride     (src_stride),
        .des_stride     (des_stride),
        .rc_enable      (rc_enable),
        .rc_done        (rc_done),
        .rc_src_addr1   (rc_src_addr1),
        .rc_src_addr2   (rc_src_addr2),
        .rc_des_addr    (rc_des_addr),
        .rc_stage_flag  (rc_stage_flag),
        .mem_src_addr1  (mem_src_addr1),
        .mem_src_addr2  (mem_src_addr2),
        .mem_des_addr   (mem_des_addr),
        .mem_stage_flag (mem_stage_flag),
        .mem_valid      (mem_valid),
        .ch_idx         (ch_idx),
        .busy           (busy),
`ifdef RESIZE_SCHED_ABORT_EN
        .abort          (abort),
        .aborted        (aborted),
`endif
        .done           (done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rc(input bit rnd, input logic [15:0] rel);
        if (rnd) begin
            rc_src_addr1 = 16'($urandom);
            rc_src_addr2 = 16'($urandom);
            rc_des_addr  = 16'($urandom);
        end else begin
            rc_src_addr1 = rel;
            rc_src_addr2 = rel ^ 16'h00FF;
            rc_des_addr  = rel + 16'h0100;
        end
        rc_stage_flag = 1'($urandom_range(0, 1));
    endtask

    // One full layer. The expected schedule comes from the timing rules:
    // channel c spans T_c+2 edges (LAUNCH, T_c RUN cycles, DRAIN), FINISH follows.
    task automatic run_layer(input int n,
                             input logic [15:0] sb, input logic [15:0] db,
                             input logic [15:0] ss, input logic [15:0] ds,
                             input int tlen [16], input bit chaos, input bit rnd_rel,
                             input logic [15:0] rel,
                             output int done_cnt, output logic [2:0][15:0] first_src);
        int off [17];
        int total, ph, c, o, prev_ph, prev_c, prev_o, done_k;
        logic [15:0] p_s1, p_s2, p_d, e16;
        logic p_flag;
        off[0] = 0;
        for (int i = 0; i < n; i++) off[i+1] = off[i] + tlen[i] + 2;
        total = off[n];
        first_src = '0;
        done_k = -1;
        num_ch = CH_W'(n);
        src_base = sb; des_base = db; src_stride = ss; des_stride = ds;
        start = 1'b1;
        rc_done = 1'b0;
        set_rc(rnd_rel, rel);
        p_s1 = rc_src_addr1; p_s2 = rc_src_addr2; p_d = rc_des_addr; p_flag = rc_stage_flag;
        prev_ph = P_IDLE; prev_c = 0; prev_o = 0;
        for (int k = 0; k <= total + 1; k++) begin
            tick();
            c = (n == 0) ? 0 : n - 1;
            o = 0;
            if (k == total) ph = P_FINISH;
            else if (k > total) ph = P_IDLE;
            else begin
                c = 0;
                while (k >= off[c+1]) c++;
                o = k - off[c];
                ph = (o == 0) ? P_LAUNCH : ((o <= tlen[c]) ? P_RUN : P_DRAIN);
            end
            check("busy", 32'(busy), 32'(ph != P_IDLE));
            check("rc_enable", 32'(rc_enable), 32'(ph == P_RUN));
            check("done", 32'(done), 32'(ph == P_FINISH));
            if (ph != P_IDLE) check("ch_idx", 32'(ch_idx), c);
            check("mem_valid", 32'(mem_valid), 32'(prev_ph == P_RUN && prev_o < tlen[prev_c]));
            check("mem_stage_flag", 32'(mem_stage_flag), 32'(p_flag));
            if (prev_ph == P_RUN) begin
                e16 = sb + 16'(prev_c) * ss + p_s1;
                check("mem_src_addr1", 32'(mem_src_addr1), 32'(e16));
                e16 = sb + 16'(prev_c) * ss + p_s2;
                check("mem_src_addr2", 32'(mem_src_addr2), 32'(e16));
                e16 = db + 16'(prev_c) * ds + p_d;
                check("mem_des_addr", 32'(mem_des_addr), 32'(e16));
                if (prev_o == 1 && prev_c < 3) first_src[prev_c] = mem_src_addr1;
            end
            if (done === 1'b1 && done_k < 0) done_k = k;
            start = 1'b0;
            if (chaos && ph != P_IDLE) begin
                start      = 1'($urandom_range(0, 1));
                num_ch     = CH_W'($urandom);
                src_base   = 16'($urandom);
                des_base   = 16'($urandom);
                src_stride = 16'($urandom);
                des_stride = 16'($urandom);
            end
            if (ph == P_RUN) rc_done = (o == tlen[c]);
            else rc_done = chaos ? 1'($urandom_range(0, 1)) : 1'b0;
            set_rc(rnd_rel, rel);
            p_s1 = rc_src_addr1; p_s2 = rc_src_addr2; p_d = rc_des_addr; p_flag = rc_stage_flag;
            prev_ph = ph; prev_c = c; prev_o = o;
        end
        start = 1'b0;
        rc_done = 1'b0;
        done_cnt = (done_k < 0) ? -1 : done_k + 2;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rc_enable"}, 32'(rc_enable), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
        check({tag, "_mem_stage_flag"}, 32'(mem_stage_flag), 32'd0);
        check({tag, "_ch_idx"}, 32'(ch_idx), 32'd0);
        check({tag, "_mem_src_addr1"}, 32'(mem_src_addr1), 32'd0);
        check({tag, "_mem_src_addr2"}, 32'(mem_src_addr2), 32'd0);
        check({tag, "_mem_des_addr"}, 32'(mem_des_addr), 32'd0);
    endtask

    // Three channels, T=6, rc_done on ch0's 6th RUN cycle; returns after edge 11 (ch1 RUN cycle 3).
    task automatic run_to_ch1_cycle3();
        num_ch = 10'd3;
        src_base = 16'h2000; src_stride = 16'h0100;
        des_base = 16'h3000; des_stride = 16'h0200;
        rc_src_addr1 = 16'h0011; rc_src_addr2 = 16'h0022; rc_des_addr = 16'h0033;
        rc_stage_flag = 1'b1;
        rc_done = 1'b0;
        start = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            tick();
            start = 1'b0;
            rc_done = (k == 6);
        end
        check("seq_rc_enable_ch1", 32'(rc_enable), 32'd1);
        check("seq_ch_idx_ch1", 32'(ch_idx), 32'd1);
        check("seq_mem_valid_ch1", 32'(mem_valid), 32'd1);
        check("seq_mem_src_addr1_ch1", 32'(mem_src_addr1), 32'h2111);
    endtask

    typedef struct packed {
        int              n;
        int              t;
        logic [15:0]     sb;
        logic [15:0]     ss;
        logic [15:0]     db;
        logic [15:0]     ds;
        logic [15:0]     rel;
        logic            chaos;
        int              exp_done;
        logic [2:0][15:0] exp_src;
    } vec_t;

    vec_t tbl [5];
    int   tl [16];
    int   dc, nch, exp_total, done_seen;
    logic [2:0][15:0] fs;

    initial begin
        tbl[0] = '{n: 1, t: 8, sb: 16'h1000, ss: 16'h0000, db: 16'h2000, ds: 16'h0000,
                   rel: 16'h0005, chaos: 1'b0, exp_done: 12,
                   exp_src: {16'h0000, 16'h0000, 16'h1005}};
        tbl[1] = '{n: 3, t: 4, sb: 16'h1000, ss: 16'h0400, db: 16'h4000, ds: 16'h1000,
                   rel: 16'h0000, chaos: 1'b0, exp_done: 20,
                   exp_src: {16'h1800, 16'h1400, 16'h1000}};
        tbl[2] = '{n: 0, t: 5, sb: 16'h0100, ss: 16'h0010, db: 16'h0000, ds: 16'h0000,
                   rel: 16'h0001, chaos: 1'b0, exp_done: 2,
                   exp_src: {16'h0000, 16'h0000, 16'h0000}};
        tbl[3] = '{n: 1, t: 3, sb: 16'hFFF0, ss: 16'h0000, db: 16'hFFFF, ds: 16'h0000,
                   rel: 16'h0020, chaos: 1'b1, exp_done: 7,
                   exp_src: {16'h0000, 16'h0000, 16'h0010}};
        tbl[4] = '{n: 2, t: 1, sb: 16'hF000, ss: 16'h1000, db: 16'h8000, ds: 16'h8000,
                   rel: 16'h0800, chaos: 1'b1, exp_done: 8,
                   exp_src: {16'h0000, 16'h0800, 16'hF800}};

        reset = 1'b1; start = 1'b0; rc_done = 1'b0;
        num_ch = 10'd5; src_base = 16'h1234; des_base = 16'h5678;
        src_stride = 16'h0010; des_stride = 16'h0020;
        rc_src_addr1 = 16'hAAAA; rc_src_addr2 = 16'h5555; rc_des_addr = 16'h0F0F;
        rc_stage_flag = 1'b1;
`ifdef RESIZE_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        tick();
        start = 1'b1;
        tick();
        check_reset_values("rst");
`ifdef RESIZE_SCHED_ABORT_EN
        check("rst_aborted", 32'(aborted), 32'd0);
`endif
        reset = 1'b0;
        start = 1'b0;
        tick();

        // Directed table.
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 16; j++) tl[j] = tbl[i].t;
            run_layer(tbl[i].n, tbl[i].sb, tbl[i].db, tbl[i].ss, tbl[i].ds, tl,
                      tbl[i].chaos, 1'b0, tbl[i].rel, dc, fs);
            check("tbl_done_cycles", dc, tbl[i].exp_done);
            for (int c = 0; c < 3; c++)
                if (c < tbl[i].n) check("tbl_first_src", 32'(fs[c]), 32'(tbl[i].exp_src[c]));
        end

        // Reset in channel 1, RUN cycle 3.
        run_to_ch1_cycle3();
        reset = 1'b1;
        tick();
        check_reset_values("midrst");
        reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("midrst_no_done_or_busy", done_seen, 0);
        for (int j = 0; j < 16; j++) tl[j] = 2;
        run_layer(2, 16'h0400, 16'h0800, 16'h0100, 16'h0100, tl, 1'b0, 1'b0, 16'h0003, dc, fs);
        check("after_rst_done_cycles", dc, 10);
        check("after_rst_ch0_src", 32'(fs[0]), 32'h0403);

`ifdef RESIZE_SCHED_ABORT_EN
        run_to_ch1_cycle3();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_done", 32'(done), 32'd1);
        check("abort_aborted", 32'(aborted), 32'd1);
        check("abort_rc_enable", 32'(rc_enable), 32'd0);
        check("abort_mem_valid", 32'(mem_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd1);
        tick();
        check("abort_done_clear", 32'(done), 32'd0);
        check("abort_aborted_clear", 32'(aborted), 32'd0);
        check("abort_busy_clear", 32'(busy), 32'd0);
`endif

        // Randomized layers.
        for (int r = 0; r < 25; r++) begin
            nch = $urandom_range(0, 4);
            exp_total = 2;
            for (int j = 0; j < 16; j++) begin
                tl[j] = $urandom_range(1, 6);
                if (j < nch) exp_total += tl[j] + 2;
            end
            run_layer(nch, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), tl,
                      1'($urandom_range(0, 1)), 1'b1, 16'h0000, dc, fs);
            check("rnd_done_cycles", dc, exp_total);
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/resize_channel_scheduler.md
# resize_channel_scheduler

Sequences the bilinear resize controller across all channels of a feature map in the upsample layer. For each channel it launches the resize controller and waits for its `done`. It also relocates the controller's plane-relative source and destination addresses into absolute feature-memory addresses using per-channel strides. It sits between the layer-level control FSM and the resize datapath/feature-memory ports.

## Interface
- `ADDR_W`, default 16 (= `ADDR_SZ`): address width.
- `CH_W`, default 10: channel-count width (max 1023 channels).

- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle command pulse; sampled only in IDLE.
- `num_ch`  in  CH_W  channels to process; latched on accepted `start`.
- `src_base`, `des_base`  in  ADDR_W  channel-0 plane base addresses; latched on `start`.
- `src_stride`, `des_stride`  in  ADDR_W  per-channel plane sizes; latched on `start`.
- `rc_enable`  out  1  level enable to the resize controller.
- `rc_done`  in  1  resize controller finished current plane.
- `rc_src_addr1`, `rc_src_addr2`, `rc_des_addr`  in  ADDR_W  plane-relative addresses from the resize controller.
- `rc_stage_flag`  in  1  stage flag from the resize controller.
- `mem_src_addr1`, `mem_src_addr2`, `mem_des_addr`  out  ADDR_W  absolute addresses, registered.
- `mem_stage_flag`  out  1  `rc_stage_flag`, registered in step with the addresses.
- `mem_valid`  out  1  absolute address outputs are valid this cycle.
- `ch_idx`  out  CH_W  channel currently being processed.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of the layer.

## Operation
- States: IDLE, LAUNCH, RUN, DRAIN, FINISH.
- IDLE: on `start`, latch all config inputs, clear `ch_idx`, and load current bases from `src_base`/`des_base`.
  - `num_ch`==0 → FINISH.
  - Otherwise → LAUNCH.
- LAUNCH: `rc_enable`=0 for exactly one cycle, which guarantees the resize controller restarts from its origin. → RUN.
- RUN: `rc_enable`=1. Stay until `rc_done`=1, then → DRAIN.
- DRAIN: `rc_enable`=0 for one cycle so the last address flushes through the output register.
  - If `ch_idx`==`num_ch`-1 → FINISH.
  - Otherwise `ch_idx`+=1, `cur_src`+=`src_stride`, `cur_des`+=`des_stride` → LAUNCH.
- FINISH: `done`=1 for one cycle → IDLE.
- Address stage, registered every cycle:
  - `mem_src_addrN` = `cur_src` + `rc_src_addrN`; `mem_des_addr` = `cur_des` + `rc_des_addr`.
  - `mem_valid` = (state==RUN) & ~`rc_done`, registered.
- All additions wrap modulo 2^ADDR_W; no overflow flag.
- `start` outside IDLE is ignored. Config inputs may change freely after acceptance.
- `rc_done` outside RUN is ignored.
- Reset values: state IDLE; `rc_enable`, `busy`, `done`, `mem_valid`, `mem_stage_flag` 0; `ch_idx` 0; all addresses 0.
- Reset mid-operation: every output takes its reset value at the next edge. `rc_enable` drops immediately at that edge, and no `done` is emitted.

## Timing
- `start` sampled at edge 0 → `busy`=1 and LAUNCH after edge 0; `rc_enable`=1 after edge 1.
- Address latency: 1 cycle from `rc_*` inputs to `mem_*` outputs.
- Per channel: 1 (LAUNCH) + T_rc (cycles in RUN, including the `rc_done` cycle) + 1 (DRAIN).
- Layer total: from `start` to `done` = 1 + N·(T_rc + 2) + 1 cycles. With `num_ch`=0, `done` is asserted 2 cycles after `start`.
- `done` and `busy` deassert together on the edge after FINISH. A new `start` is accepted in the first IDLE cycle.

## Configuration
- `RESIZE_SCHED_ABORT_EN` adds input `abort` (1 bit) and output `aborted` (1 bit, reset 0).
  - With the macro: `abort`=1 in LAUNCH/RUN/DRAIN → FINISH on the next edge, `rc_enable`=0, `mem_valid`=0.
  - `done` still pulses, and `aborted` is set for the same cycle as `done`.
  - `abort` in IDLE or FINISH is ignored.
- Without the macro: neither port exists; the FSM has no abort path.

## Test plan
- Single channel: `num_ch`=1, `src_base`=0x1000, `rc_done` after 8 RUN cycles.
  - Expect `rc_enable` high for 8 cycles.
  - Expect `mem_src_addr1` = 0x1000 + `rc_src_addr1`, one cycle late.
  - Expect `done` 12 cycles after `start`.
- Multi-channel stride: `num_ch`=3, `src_stride`=0x0400, `des_stride`=0x1000.
  - Expect `ch_idx` to step 0,1,2.
  - Expect plane-0 relative address 0 to map to 0x1000/0x1400/0x1800 (src).
  - Expect a 1-cycle `rc_enable` gap before each channel.
- Zero channels: `num_ch`=0 → `rc_enable` never asserts; `done` 2 cycles after `start`.
- Wrap and ignored start: `src_base`=0xFFF0, `rc_src_addr1`=0x0020 → `mem_src_addr1`=0x0010. A second `start` mid-run has no effect on config or state.
- Reset mid-RUN: `reset` asserted at channel 1, cycle 3.
  - Expect all outputs at reset values the next cycle and no `done`.
  - A subsequent `start` runs normally from channel 0.
- With `RESIZE_SCHED_ABORT_EN`: `abort` during channel 1 RUN → FINISH next edge; `done`=`aborted`=1 for one cycle; `rc_enable` low.
